// File: rtl/flash_loader.sv
// Boot loader: reads an image from SPI flash (READ 0x03, mode 0) and writes it to RAM as
// little-endian 32-bit words through the ramio write port; done stays high once complete.
module flash_loader #(
  parameter int unsigned StartupWaitCycles = 1000,
  parameter logic [23:0] FlashReadAddress  = 24'h000000,
  parameter int unsigned TransferByteCount = 2048,
  parameter logic [31:0] RamBaseAddress    = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        done,
  output logic        flash_clk,
  input  logic        flash_miso,
  output logic        flash_mosi,
  output logic        flash_cs_n,
  output logic        ramio_enable,
  output logic [1:0]  ramio_write_type,
  output logic [31:0] ramio_address,
  output logic [31:0] ramio_data_in,
  input  logic        ramio_busy
);

  localparam int unsigned NumWords = TransferByteCount / 4;
  localparam int unsigned IdxW     = $clog2(NumWords) + 1;
  localparam int unsigned WaitW    =
      (StartupWaitCycles > 0) ? $clog2(StartupWaitCycles + 1) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(StartupWaitCycles);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumWords - 1);
  localparam logic [31:0]      Cmd      = {8'h03, FlashReadAddress};

  typedef enum logic [2:0] {
    StStartupWait,
    StSelect,
    StSendCmd,
    StReceive,
    StWrite,
    StWaitBusy,
    StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [5:0]        bit_q, bit_d;
  logic [31:0]       shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              done_q, done_d;
  logic              en_q, en_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       packed_word;

  // Bytes arrive MSB first; the first byte received lands in the low byte of the word.
  assign packed_word = {shift_q[7:0], shift_q[15:8], shift_q[23:16], shift_q[31:24]};

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = done_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      StStartupWait: begin
        if (wait_q == WaitLast) state_d = StSelect;
        else                    wait_d  = wait_q + 1'b1;
      end
      StSelect: begin
        bit_d   = 6'd0;
        state_d = StSendCmd;
      end
      StSendCmd: begin
        bit_d = bit_q + 6'd1;
        if (bit_q == 6'd63) state_d = StReceive;
      end
      StReceive: begin
        bit_d = bit_q + 6'd1;
        // Odd phases are the flash_clk-high cycles.
        if (bit_q[0]) shift_d = {shift_q[30:0], flash_miso};
        if (bit_q == 6'd63) state_d = StWrite;
      end
      StWrite: begin
        if (!ramio_busy) begin
          en_d    = 1'b1;
          addr_d  = RamBaseAddress + (32'(idx_q) << 2);
          data_d  = packed_word;
          state_d = StWaitBusy;
        end
      end
      StWaitBusy: begin
        // The strobe cycle itself ignores busy; it is judged from the following cycle.
        if (!en_q && !ramio_busy) begin
          if (idx_q == LastIdx) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StReceive;
          end
        end
      end
      StFinish: done_d = 1'b1;
      default:  state_d = StStartupWait;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StStartupWait;
      wait_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    flash_cs_n = 1'b1;
    flash_clk  = 1'b0;
    flash_mosi = 1'b0;
    case (state_q)
      StSelect, StWrite, StWaitBusy: flash_cs_n = 1'b0;
      StSendCmd: begin
        flash_cs_n = 1'b0;
        flash_clk  = bit_q[0];
        flash_mosi = Cmd[~bit_q[5:1]];
      end
      StReceive: begin
        flash_cs_n = 1'b0;
        flash_clk  = bit_q[0];
      end
      default: ;
    endcase
  end

  assign done             = done_q;
  assign ramio_enable     = en_q;
  assign ramio_write_type = en_q ? 2'b11 : 2'b00;
  assign ramio_address    = addr_q;
  assign ramio_data_in    = data_q;

endmodule

// File: tb/tb_flash_loader.sv
// Bench for flash_loader: SPI flash model feeding a 16-byte image, write scoreboard
// derived from the image, and directed reset / backpressure / completion scenarios.
module tb_flash_loader;

  localparam int unsigned NWords = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ramio_busy = 1'b0;
  logic        flash_miso = 1'b0;
  logic        done;
  logic        flash_clk;
  logic        flash_mosi;
  logic        flash_cs_n;
  logic        ramio_enable;
  logic [1:0]  ramio_write_type;
  logic [31:0] ramio_address;
  logic [31:0] ramio_data_in;

  flash_loader #(
    .StartupWaitCycles(0),
    .FlashReadAddress (24'h000000),
    .TransferByteCount(16),
    .RamBaseAddress   (32'h00000000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .done            (done),
    .flash_clk       (flash_clk),
    .flash_miso      (flash_miso),
    .flash_mosi      (flash_mosi),
    .flash_cs_n      (flash_cs_n),
    .ramio_enable    (ramio_enable),
    .ramio_write_type(ramio_write_type),
    .ramio_address   (ramio_address),
    .ramio_data_in   (ramio_data_in),
    .ramio_busy      (ramio_busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16] = '{8'h37, 8'h01, 8'h01, 8'h00, 8'hef, 8'h00, 8'h40, 8'h00,
                           8'h78, 8'h56, 8'h34, 8'h12, 8'hef, 8'hbe, 8'had, 8'hde};

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
    return {mem[4*i+3], mem[4*i+2], mem[4*i+1], mem[4*i]};
  endfunction

  // Flash device: captures the command on rising edges, shifts data out on falling edges.
  int          rise_cnt = 0;
  int          last_rises = 0;
  logic [31:0] cmd_cap = '0;
  logic        fclk_prev = 1'b0;

  always @(flash_clk or flash_cs_n) begin : flash_model
    int bi;
    int a;
    if (flash_cs_n === 1'b1) begin
      if (rise_cnt != 0) last_rises = rise_cnt;
      rise_cnt = 0;
    end else if (flash_clk === 1'b1 && fclk_prev === 1'b0) begin
      if (rise_cnt < 32) cmd_cap = {cmd_cap[30:0], flash_mosi};
      rise_cnt++;
    end else if (flash_clk === 1'b0 && fclk_prev === 1'b1 && rise_cnt >= 32) begin
      bi = rise_cnt - 32;
      a  = int'(cmd_cap[23:0]) + bi / 8;
      flash_miso = (a < 16) ? mem[a][7 - (bi % 8)] : 1'b0;
    end
    fclk_prev = flash_clk;
  end

  // Scoreboard: every cycle, outputs are checked against the expected write sequence.
  logic rst_sampled = 1'b1;
  always @(posedge clk) rst_sampled <= rst_n;

  int   k = 0;
  logic prev_en = 1'b0;
  logic prev_cs = 1'b1;
  logic exp_done_next = 1'b0;

  always @(negedge clk) begin
    if (!rst_sampled) begin
      check("rst_done", done, 0);
      check("rst_cs_n", flash_cs_n, 1);
      check("rst_fclk", flash_clk, 0);
      check("rst_mosi", flash_mosi, 0);
      check("rst_en", ramio_enable, 0);
      check("rst_wtype", ramio_write_type, 0);
      check("rst_addr", ramio_address, 0);
      check("rst_data", ramio_data_in, 0);
      k = 0;
      prev_en = 1'b0;
      prev_cs = 1'b1;
      exp_done_next = 1'b0;
    end else begin
      check("wtype", ramio_write_type, ramio_enable ? 2'b11 : 2'b00);
      if (ramio_enable) begin
        check("strobe_len", prev_en, 0);
        if (k < NWords) begin
          check("waddr", ramio_address, 32'(4 * k));
          check("wdata", ramio_data_in, exp_word(k));
        end else begin
          check("strobe_count", k + 1, NWords);
        end
        k++;
      end
      if (exp_done_next) check("done_rise", done, 1);
      exp_done_next = 1'b0;
      if (flash_cs_n && !prev_cs && k == NWords) begin
        check("done_early", done, 0);
        exp_done_next = 1'b1;
      end
      if (done) begin
        check("done_cs", flash_cs_n, 1);
        check("done_fclk", flash_clk, 0);
        check("done_words", k, NWords);
      end
      if (flash_cs_n) check("idle_fclk", flash_clk, 0);
      prev_en = ramio_enable;
      prev_cs = flash_cs_n;
    end
  end

  task automatic wait_strobes(input int n, input int budget);
    int c = 0;
    while (k < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("strobe_wait", (k >= n) ? 1 : 0, 1);
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    ramio_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    check("cs_before_fall", flash_cs_n, 1);
    @(negedge clk);
    #1 check("cs_fall", flash_cs_n, 0);

    wait_strobes(1, 300);
    check("w0_data", ramio_data_in, 32'h00010137);
    check("w0_addr", ramio_address, 32'h0);
    check("w0_type", ramio_write_type, 2'b11);
    check("cmd", cmd_cap, 32'h03000000);

    ramio_busy = 1'b1;
    repeat (20) begin
      @(negedge clk);
      #1;
      check("bp_fclk", flash_clk, 0);
      check("bp_cs", flash_cs_n, 0);
      check("bp_en", ramio_enable, 0);
    end
    ramio_busy = 1'b0;

    wait_strobes(2, 200);
    check("w1_data", ramio_data_in, 32'h004000ef);
    check("w1_addr", ramio_address, 32'h4);
    wait_strobes(4, 400);
    check("w3_addr", ramio_address, 32'hc);

    c = 0;
    while (!done && c < 10) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("done_wait", done, 1);
    check("flash_rises", last_rises, 160);
    repeat (100) begin
      @(negedge clk);
      #1;
      check("post_fclk", flash_clk, 0);
      check("post_en", ramio_enable, 0);
      check("post_cs", flash_cs_n, 1);
      check("post_done", done, 1);
    end
    check("final_count", k, NWords);

    // Restart, then reset in the middle of the third word.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_strobes(2, 300);
    c = 0;
    while (flash_clk !== 1'b1 && c < 20) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("rx2_started", flash_clk, 1);
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 check("mid_rst_cs", flash_cs_n, 1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_strobes(1, 300);
    check("rs_data", ramio_data_in, 32'h00010137);
    check("rs_addr", ramio_address, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
